rr_arbiter8: RTL and testbench
==============================

RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 Parameter MAX_HOLD, default 16, meaning maximum consecutive cycles one requester may hold a grant (legal range 2..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  8  level request per requester; bit i = requester i.
REQ-005 grant  output  8  one-hot grant vector; all zero when no owner.
REQ-006 grant_idx  output  3  binary index of current owner; 0 when no owner.
REQ-007 grant_vld  output  1  high while an owner holds the grant.
REQ-008 timeout  output  1  one-cycle pulse when an owner is forcibly released at MAX_HOLD.

Function
REQ-009 The FSM SHALL have exactly three states: IDLE, BUSY and GAP.
REQ-010 Arbitration in IDLE or GAP SHALL select the first requester with req high, scanning ptr+1, ptr+2, ... modulo 8, where ptr is the last granted index.
REQ-011 When any req bit is sampled high in IDLE or GAP, the block SHALL enter BUSY on that same edge, with grant_idx = winner, grant_vld = 1, ptr = winner and hold_cnt = 1.
REQ-012 Grant latency SHALL be one edge: req high before edge k gives the grant visible after edge k.
REQ-013 grant SHALL always equal the one-hot decode of grant_idx ANDed with grant_vld, with at most one bit set.
REQ-014 In BUSY, if req[grant_idx] is sampled low, the FSM SHALL go to GAP and clear grant and grant_vld on that edge.
REQ-015 In BUSY with req[grant_idx] high, hold_cnt SHALL increment each edge.
REQ-016 When hold_cnt equals MAX_HOLD with req[grant_idx] high, the FSM SHALL go to GAP, clear grant and pulse timeout for exactly one cycle.
REQ-017 req bits of non-owners SHALL be ignored during BUSY.
REQ-018 GAP SHALL last exactly one cycle with grant = 0, then arbitrate per REQ-010/011, or go to IDLE if req = 0.
REQ-019 A requester released by timeout whose req stays high SHALL be re-granted only after all other active requesters in rotation order; if it is the sole requester, it SHALL be re-granted from GAP.
REQ-020 hold_cnt width SHALL be 8 bits and SHALL never wrap.
REQ-021 Any req change occurring in the same cycle as a release SHALL be evaluated only in the following GAP cycle.

Reset
REQ-022 Asserting rst_n low SHALL immediately, without a clock, force state = IDLE, grant = 0, grant_idx = 0, grant_vld = 0, timeout = 0, hold_cnt = 0 and ptr = 7, so requester 0 has first priority.
REQ-023 Reset asserted mid-BUSY SHALL drop the grant asynchronously, and no timeout pulse SHALL be generated.
REQ-024 The first arbitration SHALL occur on the first rising edge after rst_n deasserts.

Structure
REQ-025 Package arb_pkg SHALL hold N_REQ = 8, IDX_W = 3, the state encoding (IDLE = 2'd0, BUSY = 2'd1, GAP = 2'd2) and the ptr reset value 3'd7.
REQ-026 Combinational sub-module rr_pick SHALL implement the rotate-priority encoder (inputs req[7:0] and ptr[2:0]; outputs idx[2:0] and any).
REQ-027 All outputs SHALL be registered.

Verification
REQ-028 Bench SHALL cover reset release with req = 8'h01 -> grant = 8'h01, grant_idx = 0 one edge later; req drop -> GAP -> grant = 0.
REQ-029 Bench SHALL cover req = 8'h81 held, with each owner dropping after 3 cycles -> grant sequence 8'h01, 8'h80, 8'h01, with one zero cycle between grants.
REQ-030 Bench SHALL cover req = 8'h04 held permanently with MAX_HOLD = 16 -> grant held 16 cycles, timeout pulse, one GAP cycle, then re-grant of 8'h04.
REQ-031 Bench SHALL cover req = 8'h24 held permanently -> grants alternate 8'h04 / 8'h20, each ending with a timeout pulse after 16 cycles.
REQ-032 Bench SHALL cover rst_n pulsed low mid-BUSY between clock edges -> grant = 0 immediately, timeout stays 0, and after release req = 8'h02 gives grant = 8'h02.
REQ-033 Bench SHALL cover req = 8'hFF with each owner releasing after 1 cycle -> grant_idx sequence 0,1,2,...,7,0, and grant is one-hot at every sample.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
//   N_REQ      : number of requesters
//   IDX_W      : width of a requester index
//   state_t    : arbiter FSM encoding (IDLE / BUSY / GAP)
//   PTR_RESET  : last-granted pointer after reset, so requester 0 wins first
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] PTR_RESET = 3'd7;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder.
//   req [7:0] : request vector
//   ptr [2:0] : index of the last granted requester
//   idx [2:0] : first requester with req high, scanning ptr+1, ptr+2, ... mod 8
//   any       : at least one request is present (idx is 0 when none)
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  // Walk from lowest to highest priority so the last hit written wins;
  // offset 1 (ptr+1) is the highest priority and is visited last.
  always_comb begin
    idx  = '0;
    cand = '0;
    any  = |req;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = ptr + IDX_W'(k);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter with a bounded hold time.
//   clk       : clock, all state updates on the rising edge
//   rst_n     : asynchronous active-low reset
//   req       : level request per requester
//   grant     : registered one-hot grant, zero when nobody owns the grant
//   grant_idx : registered binary index of the owner, 0 when no owner
//   grant_vld : registered, high while an owner holds the grant
//   timeout   : one-cycle pulse when an owner is cut off after MAX_HOLD cycles
//   dbg_state : current FSM state for observation
//
// Handshake: req is a level; a requester keeps req high for as long as it
// wants the resource and owns it exactly while grant[i] is high. Dropping
// req releases the grant on the next edge; there is no ready/ack path back.
// Every release is followed by one GAP cycle with no owner before the next
// arbitration, and requests changing during the release edge are only seen
// in that GAP cycle.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld,
  output logic             timeout,
  output state_t           dbg_state
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [7:0]       hold_q, hold_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             vld_q, vld_d;
  logic             to_q, to_d;
  logic [N_REQ-1:0] grant_q, grant_d;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  rr_pick u_pick (
    .req (req),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    to_d    = 1'b0;

    case (state_q)
      IDLE, GAP: begin
        if (pick_any) begin
          state_d = BUSY;
          idx_d   = pick_idx;
          ptr_d   = pick_idx;
          vld_d   = 1'b1;
          hold_d  = 8'd1;
        end else begin
          state_d = IDLE;
          idx_d   = '0;
          vld_d   = 1'b0;
          hold_d  = 8'd0;
        end
      end
      BUSY: begin
        if (!req[idx_q]) begin
          state_d = GAP;
          idx_d   = '0;
          vld_d   = 1'b0;
          hold_d  = 8'd0;
        end else if (hold_q == 8'(MAX_HOLD)) begin
          // Forced release; ptr stays at the owner so it goes to the back
          // of the rotation.
          state_d = GAP;
          idx_d   = '0;
          vld_d   = 1'b0;
          hold_d  = 8'd0;
          to_d    = 1'b1;
        end else begin
          hold_d  = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        vld_d   = 1'b0;
        hold_d  = 8'd0;
      end
    endcase

    grant_d = vld_d ? (N_REQ'(1) << idx_d) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= PTR_RESET;
      hold_q  <= 8'd0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      to_q    <= 1'b0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      to_q    <= to_d;
      grant_q <= grant_d;
    end
  end

  assign grant     = grant_q;
  assign grant_idx = idx_q;
  assign grant_vld = vld_q;
  assign timeout   = to_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8 (MAX_HOLD = 16).
module tb_rr_arbiter8;
  import arb_pkg::*;

  localparam int HOLD = 16;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_vld;
  logic       timeout;
  state_t     dbg_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] idx;
    logic       vld;
    logic       to;
    state_t     st;
  } vec_t;

  vec_t vecs[$];

  rr_arbiter8 #(.MAX_HOLD(HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld),
    .timeout   (timeout),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] g, input logic [2:0] i,
                     input logic v, input logic t);
    checks++;
    if (grant !== g || grant_idx !== i || grant_vld !== v || timeout !== t ||
        !$onehot0(grant)) begin
      errors++;
      $display("FAIL %s: got grant=%h idx=%0d vld=%b to=%b, want grant=%h idx=%0d vld=%b to=%b",
               name, grant, grant_idx, grant_vld, timeout, g, i, v, t);
    end
  endtask

  task automatic chk_state(input string name, input state_t s);
    checks++;
    if (dbg_state !== s) begin
      errors++;
      $display("FAIL %s: got state=%0d want state=%0d", name, dbg_state, s);
    end
  endtask

  // Async assert with immediate check, hold across one edge, release.
  task automatic do_reset();
    req   = 8'h00;
    rst_n = 1'b0;
    #1;
    chk("reset_async", 8'h00, 3'd0, 1'b0, 1'b0);
    chk_state("reset_state", IDLE);
    step();
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic r, input logic [7:0] q, input logic [7:0] g,
                              input logic [2:0] i, input logic v, input logic t,
                              input state_t s);
    vec_t x;
    x.rst = r; x.req = q; x.grant = g; x.idx = i; x.vld = v; x.to = t; x.st = s;
    return x;
  endfunction

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;

    // reset release, single requester, drop -> GAP -> IDLE
    vecs.push_back(mk(1, 8'h01, 8'h01, 0, 1, 0, BUSY));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, GAP));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, IDLE));

    // 8'h81, each owner holds 3 cycles then drops for one sample
    vecs.push_back(mk(1, 8'h81, 8'h01, 0, 1, 0, BUSY));
    vecs.push_back(mk(0, 8'h81, 8'h01, 0, 1, 0, BUSY));
    vecs.push_back(mk(0, 8'h81, 8'h01, 0, 1, 0, BUSY));
    vecs.push_back(mk(0, 8'h80, 8'h00, 0, 0, 0, GAP));
    vecs.push_back(mk(0, 8'h81, 8'h80, 7, 1, 0, BUSY));
    vecs.push_back(mk(0, 8'h81, 8'h80, 7, 1, 0, BUSY));
    vecs.push_back(mk(0, 8'h81, 8'h80, 7, 1, 0, BUSY));
    vecs.push_back(mk(0, 8'h01, 8'h00, 0, 0, 0, GAP));
    vecs.push_back(mk(0, 8'h81, 8'h01, 0, 1, 0, BUSY));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, GAP));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, IDLE));

    // 8'hFF, each owner releases after one cycle -> indices 0..7, 0
    for (int i = 0; i < 8; i++) begin
      vecs.push_back(mk(i == 0, 8'hFF, 8'h01 << i, 3'(i), 1, 0, BUSY));
      vecs.push_back(mk(0, 8'hFF & ~(8'h01 << i), 8'h00, 0, 0, 0, GAP));
    end
    vecs.push_back(mk(0, 8'hFF, 8'h01, 0, 1, 0, BUSY));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, GAP));

    // reset state
    step();
    chk("reset_init", 8'h00, 3'd0, 1'b0, 1'b0);
    chk_state("reset_init_state", IDLE);
    rst_n = 1'b1;

    foreach (vecs[n]) begin
      if (vecs[n].rst) do_reset();
      req = vecs[n].req;
      step();
      chk($sformatf("vec%0d", n), vecs[n].grant, vecs[n].idx, vecs[n].vld, vecs[n].to);
      chk_state($sformatf("vec%0d_state", n), vecs[n].st);
    end

    // sole requester 8'h04: 16 cycles, timeout, one GAP, re-grant
    do_reset();
    req = 8'h04;
    for (int c = 0; c < HOLD; c++) begin
      step();
      chk($sformatf("hold04_c%0d", c), 8'h04, 3'd2, 1'b1, 1'b0);
    end
    step();
    chk("hold04_timeout", 8'h00, 3'd0, 1'b0, 1'b1);
    chk_state("hold04_gap", GAP);
    step();
    chk("hold04_regrant", 8'h04, 3'd2, 1'b1, 1'b0);
    req = 8'h00;
    step();
    step();

    // 8'h24: alternate 8'h04 / 8'h20, each ended by timeout
    do_reset();
    req = 8'h24;
    for (int r = 0; r < 4; r++) begin
      logic [7:0] g;
      logic [2:0] gi;
      g  = (r % 2 == 0) ? 8'h04 : 8'h20;
      gi = (r % 2 == 0) ? 3'd2 : 3'd5;
      for (int c = 0; c < HOLD; c++) begin
        step();
        chk($sformatf("alt_r%0d_c%0d", r, c), g, gi, 1'b1, 1'b0);
      end
      step();
      chk($sformatf("alt_r%0d_timeout", r), 8'h00, 3'd0, 1'b0, 1'b1);
    end
    req = 8'h00;
    step();

    // reset mid-BUSY at hold = MAX_HOLD, between edges: no timeout
    do_reset();
    req = 8'h04;
    for (int c = 0; c < HOLD; c++) step();
    chk("midrst_before", 8'h04, 3'd2, 1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_async", 8'h00, 3'd0, 1'b0, 1'b0);
    chk_state("midrst_state", IDLE);
    step();
    chk("midrst_held", 8'h00, 3'd0, 1'b0, 1'b0);
    req   = 8'h02;
    rst_n = 1'b1;
    step();
    chk("midrst_regrant", 8'h02, 3'd1, 1'b1, 1'b0);
    step();
    chk("midrst_hold", 8'h02, 3'd1, 1'b1, 1'b0);
    req = 8'h00;
    step();
    chk("midrst_drop", 8'h00, 3'd0, 1'b0, 1'b0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
